spw_link_start_fsm: RTL and testbench

- SpaceWire link-interface initialisation state machine per ECSS-E-ST-50-12C.
- Sits directly downstream of the autoStart / linkStart / linkDisable control registers, which are one-bit Avalon PIO outputs.
- Consumes those control levels and receiver event strobes.
- Drives transmitter and receiver enables, and reports link state to software.

---
 rtl/spw_link_start_fsm.sv | 146 ++++++++++++++
 tb/tb_spw_link_start_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spw_link_start_fsm.sv
// rtl/spw_link_start_fsm.sv - SpaceWire link-interface initialisation state machine
module spw_link_start_fsm #(
    parameter int T64_CYCLES  = 320,
    parameter int T128_CYCLES = 640
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       auto_start,
    input  logic       link_start,
    input  logic       link_disable,
    input  logic       got_null,
    input  logic       got_fct,
    input  logic       got_nchar,
    input  logic       got_time_code,
    input  logic       rx_error,
    input  logic       credit_error,
    output logic       rx_reset,
    output logic       tx_enable,
    output logic       send_fcts,
    output logic       data_enable,
    output logic [2:0] link_state,
    output logic       link_error
);

    localparam int TW = $clog2(T128_CYCLES);

    localparam logic [TW-1:0] T64_LAST  = TW'(T64_CYCLES - 1);
    localparam logic [TW-1:0] T128_LAST = TW'(T128_CYCLES - 1);

    localparam logic [2:0] S_ERROR_RESET = 3'd0;
    localparam logic [2:0] S_ERROR_WAIT  = 3'd1;
    localparam logic [2:0] S_READY       = 3'd2;
    localparam logic [2:0] S_STARTED     = 3'd3;
    localparam logic [2:0] S_CONNECTING  = 3'd4;
    localparam logic [2:0] S_RUN         = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          null_seen_q, null_seen_d;
    logic          link_error_q, link_error_d;

    logic t64;
    logic t128;
    logic perr;
    logic link_en;
    logic err_entry;

    assign t64  = (timer_q == T64_LAST);
    assign t128 = (timer_q == T128_LAST);

    // Parity-style error: a data/control char arriving after the first NULL
    // uses the registered null_seen, so the NULL itself never counts.
    assign perr    = rx_error | (null_seen_q & (got_fct | got_nchar | got_time_code));
    assign link_en = ~link_disable & (link_start | (auto_start & null_seen_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_ERROR_RESET;
            timer_q      <= '0;
            null_seen_q  <= 1'b0;
            link_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            null_seen_q  <= null_seen_d;
            link_error_q <= link_error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_entry = 1'b0;
        case (state_q)
            S_ERROR_RESET: begin
                if (t64) begin
                    state_d = S_ERROR_WAIT;
                end
            end
            S_ERROR_WAIT: begin
                if (perr) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end else if (t128) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (perr) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end else if (link_en) begin
                    state_d = S_STARTED;
                end
            end
            S_STARTED: begin
                if (rx_error | got_fct | got_nchar | got_time_code) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end else if (got_null | null_seen_q) begin
                    state_d = S_CONNECTING;
                end else if (t128) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end
            end
            S_CONNECTING: begin
                if (rx_error | got_nchar | got_time_code) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end else if (got_fct) begin
                    state_d = S_RUN;
                end else if (t128) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end
            end
            S_RUN: begin
                if (rx_error | credit_error) begin
                    state_d   = S_ERROR_RESET;
                    err_entry = 1'b1;
                end else if (link_disable) begin
                    state_d = S_ERROR_RESET;
                end
            end
            default: begin
                state_d = S_ERROR_RESET;
            end
        endcase
    end

    always_comb begin
        timer_d      = (state_d != state_q) ? '0 : timer_q + TW'(1);
        null_seen_d  = (state_q == S_ERROR_RESET) ? 1'b0 : (null_seen_q | got_null);
        link_error_d = err_entry;
    end

    always_comb begin
        rx_reset    = (state_q == S_ERROR_RESET);
        tx_enable   = (state_q == S_STARTED) || (state_q == S_CONNECTING) || (state_q == S_RUN);
        send_fcts   = (state_q == S_CONNECTING) || (state_q == S_RUN);
        data_enable = (state_q == S_RUN);
        link_state  = state_q;
        link_error  = link_error_q;
    end

endmodule

// File: tb/tb_spw_link_start_fsm.sv
// tb/tb_spw_link_start_fsm.sv - directed scoreboard bench for spw_link_start_fsm
module tb_spw_link_start_fsm;

    logic       clk;
    logic       reset_n;
    logic       auto_start, link_start, link_disable;
    logic       got_null, got_fct, got_nchar, got_time_code;
    logic       rx_error, credit_error;
    logic       rx_reset, tx_enable, send_fcts, data_enable, link_error;
    logic [2:0] link_state;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string      tag;
        logic [7:0] vec;
    } exp_t;

    exp_t sb_q[$];

    spw_link_start_fsm #(
        .T64_CYCLES (8),
        .T128_CYCLES(16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .auto_start   (auto_start),
        .link_start   (link_start),
        .link_disable (link_disable),
        .got_null     (got_null),
        .got_fct      (got_fct),
        .got_nchar    (got_nchar),
        .got_time_code(got_time_code),
        .rx_error     (rx_error),
        .credit_error (credit_error),
        .rx_reset     (rx_reset),
        .tx_enable    (tx_enable),
        .send_fcts    (send_fcts),
        .data_enable  (data_enable),
        .link_state   (link_state),
        .link_error   (link_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {link_state, rx_reset, tx_enable, send_fcts, data_enable, link_error}
    function automatic logic [7:0] model(input logic [2:0] st, input logic le);
        logic rr, te, sf, de;
        rr = (st == 3'd0);
        te = (st == 3'd3) || (st == 3'd4) || (st == 3'd5);
        sf = (st == 3'd4) || (st == 3'd5);
        de = (st == 3'd5);
        return {st, rr, te, sf, de, le};
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] st, input logic le);
        exp_t e;
        e.tag = tag;
        e.vec = model(st, le);
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [7:0] obs;
        n_total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end else begin
            e   = sb_q.pop_front();
            obs = {link_state, rx_reset, tx_enable, send_fcts, data_enable, link_error};
            assert (obs === e.vec) n_pass++;
            else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
        end
    endtask

    task automatic tick(input string tag, input logic [2:0] st, input logic le);
        push_exp(tag, st, le);
        @(posedge clk);
        #1;
        pop_check();
        got_null      = 1'b0;
        got_fct       = 1'b0;
        got_nchar     = 1'b0;
        got_time_code = 1'b0;
        rx_error      = 1'b0;
        credit_error  = 1'b0;
    endtask

    task automatic check_now(input string tag, input logic [2:0] st, input logic le);
        push_exp(tag, st, le);
        pop_check();
    endtask

    // Covers the cycles after the first ErrorReset cycle through arrival in Ready.
    task automatic from_error_reset();
        for (int i = 0; i < 7; i++) tick("er_dwell", 3'd0, 1'b0);
        tick("er_to_wait", 3'd1, 1'b0);
        for (int i = 0; i < 15; i++) tick("wait_dwell", 3'd1, 1'b0);
        tick("wait_to_ready", 3'd2, 1'b0);
    endtask

    task automatic go_run();
        link_start = 1'b1;
        tick("run_started", 3'd3, 1'b0);
        link_start = 1'b0;
        got_null = 1'b1;
        tick("run_connecting", 3'd4, 1'b0);
        got_fct = 1'b1;
        tick("run_run", 3'd5, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        auto_start    = 1'b0;
        link_start    = 1'b0;
        link_disable  = 1'b0;
        got_null      = 1'b0;
        got_fct       = 1'b0;
        got_nchar     = 1'b0;
        got_time_code = 1'b0;
        rx_error      = 1'b0;
        credit_error  = 1'b0;

        #12;
        check_now("reset_state", 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        from_error_reset();
        for (int i = 0; i < 3; i++) tick("ready_hold", 3'd2, 1'b0);

        link_start = 1'b1;
        tick("ls_started", 3'd3, 1'b0);
        link_start = 1'b0;
        tick("ls_started_w1", 3'd3, 1'b0);
        tick("ls_started_w2", 3'd3, 1'b0);
        got_null = 1'b1;
        tick("ls_connecting", 3'd4, 1'b0);
        tick("ls_connecting_w", 3'd4, 1'b0);
        got_fct = 1'b1;
        tick("ls_run", 3'd5, 1'b0);
        tick("ls_run_hold", 3'd5, 1'b0);

        credit_error = 1'b1;
        tick("credit_err", 3'd0, 1'b1);
        from_error_reset();

        auto_start = 1'b1;
        got_null   = 1'b1;
        tick("as_null_ready", 3'd2, 1'b0);
        tick("as_started", 3'd3, 1'b0);
        tick("as_connecting", 3'd4, 1'b0);
        for (int i = 0; i < 15; i++) tick("conn_dwell", 3'd4, 1'b0);
        auto_start = 1'b0;
        tick("conn_timeout", 3'd0, 1'b1);
        from_error_reset();

        auto_start   = 1'b1;
        link_disable = 1'b1;
        got_null     = 1'b1;
        tick("dis_ready0", 3'd2, 1'b0);
        tick("dis_ready1", 3'd2, 1'b0);
        tick("dis_ready2", 3'd2, 1'b0);
        auto_start   = 1'b0;
        link_disable = 1'b0;
        got_fct      = 1'b1;
        tick("ready_perr", 3'd0, 1'b1);
        from_error_reset();

        link_start = 1'b1;
        tick("to_started", 3'd3, 1'b0);
        link_start = 1'b0;
        for (int i = 0; i < 15; i++) tick("started_dwell", 3'd3, 1'b0);
        tick("started_timeout", 3'd0, 1'b1);
        tick("timeout_pulse_end", 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick("er_dwell", 3'd0, 1'b0);
        tick("er_to_wait", 3'd1, 1'b0);
        for (int i = 0; i < 15; i++) tick("wait_dwell", 3'd1, 1'b0);
        tick("wait_to_ready", 3'd2, 1'b0);

        go_run();
        link_disable = 1'b1;
        tick("run_disable", 3'd0, 1'b0);
        link_disable = 1'b0;
        from_error_reset();

        link_start = 1'b1;
        tick("c_started", 3'd3, 1'b0);
        link_start = 1'b0;
        got_null = 1'b1;
        tick("c_connecting", 3'd4, 1'b0);
        rx_error = 1'b1;
        got_fct  = 1'b1;
        tick("err_beats_fct", 3'd0, 1'b1);
        for (int i = 0; i < 7; i++) tick("er_dwell", 3'd0, 1'b0);
        tick("er_to_wait", 3'd1, 1'b0);
        got_null = 1'b1;
        tick("wait_null", 3'd1, 1'b0);
        got_nchar = 1'b1;
        tick("wait_perr", 3'd0, 1'b1);
        from_error_reset();

        go_run();
        reset_n = 1'b0;
        #2;
        check_now("async_reset", 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        from_error_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
